// File: rtl/mii_pkg.sv
// Shared MII definitions: nibble constants, CRC-32 parameters and the TX state encoding.
package mii_pkg;

    localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hD;
    localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam int          FCS_NIBBLES  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_LO,
        ST_HI,
        ST_FCS,
        ST_ERR,
        ST_IFG
    } tx_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte step of the reflected Ethernet CRC-32; also used by the receive core's FCS check.
module crc32_byte
    import mii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // NOTE: blocking assignments here are intentional; the loop unrolls into eight chained XOR stages.
    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/mii_tx_core.sv
// MII transmit engine: byte stream in, preamble/SFD/data/[FCS]/IFG out on 4-bit MII TX pins.
// Define MII_TX_CRC_EN to append a CRC-32 FCS after the last data byte.
module mii_tx_core
    import mii_pkg::*;
#(
    parameter int PREAMBLE_NIBBLES = 15,
    parameter int IFG_NIBBLES      = 24,
    parameter int SYNC_STAGES      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       busy,
    output logic       underrun,
    input  logic       mii_tx_clk,
    output logic       mii_tx_en,
    output logic       mii_tx_er,
    output logic [3:0] mii_txd
);

    localparam int CNT_W = $clog2(max_int(max_int(PREAMBLE_NIBBLES, IFG_NIBBLES), FCS_NIBBLES) + 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_NIBBLES - 1);
    // The IDLE tick that launches the next preamble supplies the final gap nibble.
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_NIBBLES - 2);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic                   tick;

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             byte_q, byte_d;
    logic                   last_q, last_d;
    logic                   tx_en_q, tx_en_d;
    logic                   tx_er_q, tx_er_d;
    logic [3:0]             txd_q, txd_d;
    logic                   underrun_q, underrun_d;

`ifdef MII_TX_CRC_EN
    localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(FCS_NIBBLES - 1);

    logic [31:0] crc_q, crc_d, crc_next, fcs;
    logic [2:0]  fcs_idx;

    crc32_byte u_crc (
        .crc_in  (crc_q),
        .data    (s_data),
        .crc_out (crc_next)
    );

    always_comb begin
        fcs     = ~crc_q;
        fcs_idx = cnt_q[2:0] + 3'd1;
        crc_d   = crc_q;
        if (tick && state_q == ST_IDLE && s_valid) begin
            crc_d = CRC32_INIT;
        end else if (s_ready && s_valid) begin
            crc_d = crc_next;
        end
    end
`endif

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], mii_tx_clk};
        edge_d = sync_q[SYNC_STAGES-1];
        tick   = sync_q[SYNC_STAGES-1] & ~edge_q;
    end

    // NOTE: every variable gets its hold/default value first, so no path through the case can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        last_d     = last_q;
        tx_en_d    = tx_en_q;
        tx_er_d    = tx_er_q;
        txd_d      = txd_q;
        underrun_d = 1'b0;
        s_ready    = 1'b0;

        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (s_valid) begin
                        state_d = ST_PRE;
                        cnt_d   = '0;
                        tx_en_d = 1'b1;
                        txd_d   = PREAMBLE_NIB;
                    end
                end
                ST_PRE: begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = ST_SFD;
                        txd_d   = SFD_NIB;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SFD, ST_HI: begin
                    if (state_q == ST_HI && last_q) begin
`ifdef MII_TX_CRC_EN
                        state_d = ST_FCS;
                        cnt_d   = '0;
                        txd_d   = fcs[3:0];
`else
                        state_d = ST_IFG;
                        cnt_d   = '0;
                        tx_en_d = 1'b0;
                        txd_d   = '0;
`endif
                    end else begin
                        s_ready = 1'b1;
                        if (s_valid) begin
                            byte_d  = s_data;
                            last_d  = s_last;
                            state_d = ST_LO;
                            txd_d   = s_data[3:0];
                        end else begin
                            // Source starved mid-frame: poison the frame with one TX_ER nibble.
                            underrun_d = 1'b1;
                            state_d    = ST_ERR;
                            tx_er_d    = 1'b1;
                            txd_d      = '0;
                        end
                    end
                end
                ST_LO: begin
                    state_d = ST_HI;
                    txd_d   = byte_q[7:4];
                end
                ST_ERR: begin
                    state_d = ST_IFG;
                    cnt_d   = '0;
                    tx_en_d = 1'b0;
                    tx_er_d = 1'b0;
                    txd_d   = '0;
                end
`ifdef MII_TX_CRC_EN
                ST_FCS: begin
                    if (cnt_q == FCS_LAST) begin
                        state_d = ST_IFG;
                        cnt_d   = '0;
                        tx_en_d = 1'b0;
                        txd_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        txd_d = fcs[{fcs_idx, 2'b00} +: 4];
                    end
                end
`endif
                ST_IFG: begin
                    if (cnt_q == IFG_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tx_en_d = 1'b0;
                    tx_er_d = 1'b0;
                    txd_d   = '0;
                end
            endcase
        end
    end

    // NOTE: synchronous reset lives inside the clocked branch, not in the sensitivity list; state uses <= only.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            edge_q     <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            byte_q     <= '0;
            last_q     <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            txd_q      <= '0;
            underrun_q <= 1'b0;
`ifdef MII_TX_CRC_EN
            crc_q      <= '0;
`endif
        end else begin
            sync_q     <= sync_d;
            edge_q     <= edge_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            last_q     <= last_d;
            tx_en_q    <= tx_en_d;
            tx_er_q    <= tx_er_d;
            txd_q      <= txd_d;
            underrun_q <= underrun_d;
`ifdef MII_TX_CRC_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign underrun  = underrun_q;
    assign mii_tx_en = tx_en_q;
    assign mii_tx_er = tx_er_q;
    assign mii_txd   = txd_q;

endmodule

// File: tb/tb_mii_tx_core.sv
// Directed bench for mii_tx_core: expected MII nibbles queued at drive time, popped at each PHY sample edge.
module tb_mii_tx_core;

    logic       clk;
    logic       reset;
    logic       mii_tx_clk;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       busy;
    logic       underrun;
    logic       mii_tx_en;
    logic       mii_tx_er;
    logic [3:0] mii_txd;

    int checks    = 0;
    int failures  = 0;
    int zero_run  = 0;
    int last_gap  = 0;
    int ready_cnt = 0;
    int under_cnt = 0;
    int nib_cnt   = 0;
    bit mon_en    = 1'b0;

    logic [4:0] exp_q[$];   // {tx_er, txd} for every nibble sampled with tx_en=1
    logic [7:0] frm[$];

    mii_tx_core dut (
        .clk        (clk),
        .reset      (reset),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .busy       (busy),
        .underrun   (underrun),
        .mii_tx_clk (mii_tx_clk),
        .mii_tx_en  (mii_tx_en),
        .mii_tx_er  (mii_tx_er),
        .mii_txd    (mii_txd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Offset so the PHY sample edge never coincides with a clk edge.
    initial begin
        mii_tx_clk = 1'b0;
        #2;
        forever #20 mii_tx_clk = ~mii_tx_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic push_preamble();
        for (int i = 0; i < 15; i++) exp_q.push_back({1'b0, 4'h5});
        exp_q.push_back({1'b0, 4'hD});
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back({1'b0, b[3:0]});
        exp_q.push_back({1'b0, b[7:4]});
    endtask

    task automatic push_fcs(input logic [31:0] v);
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, v[4*i +: 4]});
    endtask

    task automatic push_frame();
        logic [31:0] crc;
        crc = 32'hFFFFFFFF;
        push_preamble();
        for (int i = 0; i < frm.size(); i++) begin
            push_byte(frm[i]);
            crc = crc_model(crc, frm[i]);
        end
`ifdef MII_TX_CRC_EN
        push_fcs(~crc);
`endif
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, output bit ok);
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        ok      = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("handshake", ok, 1);
        if (ok) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame();
        bit ok;
        for (int i = 0; i < frm.size(); i++) begin
            send_byte(frm[i], (i == frm.size() - 1), ok);
            if (!ok) break;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, done, 1);
    endtask

    // PHY-side monitor: the PHY samples TXD on the rising TX_CLK edge.
    always @(posedge mii_tx_clk) begin
        if (mon_en) begin
            if (mii_tx_en) begin
                if (zero_run > 0) last_gap = zero_run;
                zero_run = 0;
                check("sb_nonempty", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check($sformatf("nibble_%0d", nib_cnt), {mii_tx_er, mii_txd}, exp_q.pop_front());
                end
                nib_cnt++;
            end else begin
                zero_run++;
                check("idle_nibble", {mii_tx_er, mii_txd}, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (s_ready)  ready_cnt++;
            if (underrun) under_cnt++;
        end
    end

    initial begin
        bit ok;
        int r0;
        int u0;

        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_tx_en", mii_tx_en, 0);
        check("rst_tx_er", mii_tx_er, 0);
        check("rst_txd", mii_txd, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single-byte frame.
        frm = '{8'hA5};
        push_frame();
        send_frame();
        check("a5_busy", busy, 1);
        wait_idle("a5_done");

        // Two-byte frame: exactly two s_ready pulses.
        r0  = ready_cnt;
        frm = '{8'h12, 8'h34};
        push_frame();
        send_frame();
        wait_idle("two_byte_done");
        check("ready_pulses", ready_cnt - r0, 2);

`ifdef MII_TX_CRC_EN
        // Standard check string; FCS nibbles come from the published CRC value.
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        push_preamble();
        for (int i = 0; i < frm.size(); i++) push_byte(frm[i]);
        push_fcs(32'hCBF43926);
        send_frame();
        wait_idle("crc_check_done");
`endif

        // Underrun after the first byte of a three-byte frame.
        u0 = under_cnt;
        push_preamble();
        push_byte(8'h01);
        exp_q.push_back({1'b1, 4'h0});
        send_byte(8'h01, 1'b0, ok);
        s_valid = 1'b0;
        wait_idle("underrun_done");
        check("underrun_cycles", under_cnt - u0, 1);

        // Back-to-back frames with s_valid held high in between.
        frm = '{8'h11, 8'h22};
        push_frame();
        send_frame();
        frm = '{8'h33, 8'h44, 8'h55};
        push_frame();
        send_frame();
        wait_idle("b2b_done");
        check("ifg_gap", last_gap, 24);

        // Reset while the second byte's low nibble is on the wire.
        frm = '{8'hC1, 8'hC2, 8'hC3};
        push_frame();
        send_byte(8'hC1, 1'b0, ok);
        send_byte(8'hC2, 1'b0, ok);
        s_valid = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tx_en", mii_tx_en, 0);
        check("midrst_tx_er", mii_tx_er, 0);
        check("midrst_s_ready", s_ready, 0);
        check("midrst_busy", busy, 0);
        reset = 1'b0;
        exp_q.delete();

        frm = '{8'h5A};
        push_frame();
        send_frame();
        wait_idle("post_reset_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
